// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings for the TX/RX pair, frame width and
// the default bit period.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 10417;
  localparam int DATA_BITS            = 8;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_CLEANUP   = 3'd4;
  localparam logic [2:0] RX_WAIT_IDLE = 3'd5;

  localparam logic [2:0] TX_IDLE      = 3'd0;
  localparam logic [2:0] TX_START     = 3'd1;
  localparam logic [2:0] TX_DATA      = 3'd2;
  localparam logic [2:0] TX_STOP      = 3'd3;
  localparam logic [2:0] TX_CLEANUP   = 3'd4;

  // Terminal value of the 16-bit bit-period counter.
  function automatic logic [15:0] last_count(input int clks_per_bit);
    return 16'(clks_per_bit - 1);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start edge.
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic r_Meta_p0;
  logic r_Sync_p1;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Meta_p0 <= 1'b1;
      r_Sync_p1 <= 1'b1;
    end else begin
      r_Meta_p0 <= i_Async;
      r_Sync_p1 <= r_Meta_p0;
    end
  end

  assign o_Sync = r_Sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit of a synchronised serial line and
// reports either a good byte (one-cycle o_Rx_DV) or a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam int          HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] HALF_CNT = 16'(HALF_BIT);
  localparam logic [15:0] LAST_CNT = last_count(CLKS_PER_BIT);
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

  logic        r_Rx;
  logic [2:0]  r_State;
  logic [15:0] r_Clk_Count;
  logic [2:0]  r_Bit_Index;
  logic [7:0]  r_Shift;

  uart_rx_sync u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_Rx_Serial),
    .o_Sync  (r_Rx)
  );

  // Shift register is pure data: it is only ever read after a full frame.
  always_ff @(posedge i_Clock) begin
    if (r_State == RX_DATA && r_Clk_Count == LAST_CNT)
      r_Shift[r_Bit_Index] <= r_Rx;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State        <= RX_IDLE;
      r_Clk_Count    <= 16'd0;
      r_Bit_Index    <= 3'd0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= 8'h00;
      o_Rx_Active    <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      case (r_State)
        RX_IDLE: begin
          r_Clk_Count <= 16'd0;
          r_Bit_Index <= 3'd0;
          if (!r_Rx) begin
            r_State     <= RX_START;
            o_Rx_Active <= 1'b1;
          end
        end
        RX_START: begin
          if (r_Clk_Count == HALF_CNT) begin
            r_Clk_Count <= 16'd0;
            if (!r_Rx) begin
              r_State <= RX_DATA;
            end else begin
              r_State     <= RX_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_Clk_Count == LAST_CNT) begin
            r_Clk_Count <= 16'd0;
            if (r_Bit_Index != LAST_IDX) begin
              r_Bit_Index <= r_Bit_Index + 3'd1;
            end else begin
              r_Bit_Index <= 3'd0;
              r_State     <= RX_STOP;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_Clk_Count == LAST_CNT) begin
            r_Clk_Count <= 16'd0;
            if (r_Rx) begin
              o_Rx_Byte <= r_Shift;
              o_Rx_DV   <= 1'b1;
              r_State   <= RX_CLEANUP;
            end else begin
              o_Rx_Frame_Err <= 1'b1;
              r_State        <= RX_WAIT_IDLE;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end
        RX_CLEANUP: begin
          o_Rx_Active <= 1'b0;
          r_State     <= RX_IDLE;
        end
        RX_WAIT_IDLE: begin
          // A held-low (break) line parks here so it cannot retrigger a frame.
          if (r_Rx) begin
            o_Rx_Active <= 1'b0;
            r_State     <= RX_IDLE;
          end
        end
        default: begin
          r_State     <= RX_IDLE;
          r_Clk_Count <= 16'd0;
          r_Bit_Index <= 3'd0;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two receivers (fast and slow bit period) driven by a
// behavioural serialiser, with event logs compared against frame-level expectations.
module tb_uart_rx;

  localparam int CPB_A = 8;
  localparam int CPB_B = 87;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       dv_a, act_a, fe_a, dv_b, act_b, fe_b;
  logic [7:0] rxb_a, rxb_b;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a),
    .o_Rx_DV(dv_a), .o_Rx_Byte(rxb_a), .o_Rx_Active(act_a), .o_Rx_Frame_Err(fe_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b),
    .o_Rx_DV(dv_b), .o_Rx_Byte(rxb_b), .o_Rx_Active(act_b), .o_Rx_Frame_Err(fe_b)
  );

  // Event logs gathered on the falling edge
  logic [7:0] dvb_a[$], dvb_b[$];
  int         dvc_a[$], dvc_b[$], fec_a[$], fec_b[$];
  int         act_cnt_a = 0, viol_a = 0, viol_b = 0;
  logic       pdv_a = 1'b0, pfe_a = 1'b0, pdv_b = 1'b0, pfe_b = 1'b0;

  always @(negedge clk) begin
    if (dv_a === 1'b1) begin dvb_a.push_back(rxb_a); dvc_a.push_back(cyc); end
    if (fe_a === 1'b1) fec_a.push_back(cyc);
    if (act_a === 1'b1) act_cnt_a++;
    if ((dv_a && fe_a) || (dv_a && pdv_a) || (fe_a && pfe_a)) viol_a++;
    pdv_a = dv_a; pfe_a = fe_a;
    if (dv_b === 1'b1) begin dvb_b.push_back(rxb_b); dvc_b.push_back(cyc); end
    if (fe_b === 1'b1) fec_b.push_back(cyc);
    if ((dv_b && fe_b) || (dv_b && pdv_b) || (fe_b && pfe_b)) viol_b++;
    pdv_b = dv_b; pfe_b = fe_b;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    dvb_a.delete(); dvc_a.delete(); fec_a.delete(); act_cnt_a = 0;
    dvb_b.delete(); dvc_b.delete(); fec_b.delete();
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  // Serialise one 8N1 frame; k returns the cycle at which the start bit began.
  task automatic send(input int which, input logic [7:0] b, input logic stop, output int k);
    int cpb;
    cpb = (which == 0) ? CPB_A : CPB_B;
    k = cyc;
    drive(which, 1'b0); tick(cpb);
    for (int i = 0; i < 8; i++) begin drive(which, b[i]); tick(cpb); end
    drive(which, stop); tick(cpb);
  endtask

  // Two synchroniser cycles plus one FSM cycle to see the start, then the
  // centre of the stop bit, then one cycle for the registered pulse.
  function automatic int exp_cyc(input int k, input int cpb);
    return k + 3 + 1 + (cpb - 1) / 2 + 9 * cpb;
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    tick(3);
    n_tests++; if (dv_a !== 1'b0) begin n_fail++; $display("FAIL reset_dv_a got %b want 0", dv_a); end
    n_tests++; if (rxb_a !== 8'h00) begin n_fail++; $display("FAIL reset_byte_a got %h want 00", rxb_a); end
    n_tests++; if (act_a !== 1'b0) begin n_fail++; $display("FAIL reset_act_a got %b want 0", act_a); end
    n_tests++; if (fe_a !== 1'b0) begin n_fail++; $display("FAIL reset_fe_a got %b want 0", fe_a); end
    n_tests++; if ({dv_b, act_b, fe_b, rxb_b} !== 11'd0) begin n_fail++; $display("FAIL reset_b got %h want 0", {dv_b, act_b, fe_b, rxb_b}); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_single();
    int k;
    clear_mon();
    send(0, 8'h55, 1'b1, k);
    tick(2 * CPB_A);
    n_tests++; if (dvb_a.size() !== 1) begin n_fail++; $display("FAIL single_dv_count got %0d want 1", dvb_a.size()); end
    if (dvb_a.size() >= 1) begin
      n_tests++; if (dvb_a[0] !== 8'h55) begin n_fail++; $display("FAIL single_byte got %h want 55", dvb_a[0]); end
      n_tests++; if (dvc_a[0] !== exp_cyc(k, CPB_A)) begin n_fail++; $display("FAIL single_dv_time got %0d want %0d", dvc_a[0], exp_cyc(k, CPB_A)); end
    end
    n_tests++; if (act_cnt_a !== 77) begin n_fail++; $display("FAIL single_active_cycles got %0d want 77", act_cnt_a); end
    n_tests++; if (fec_a.size() !== 0) begin n_fail++; $display("FAIL single_no_fe got %0d want 0", fec_a.size()); end
    n_tests++; if (rxb_a !== 8'h55) begin n_fail++; $display("FAIL single_byte_hold got %h want 55", rxb_a); end
  endtask

  task automatic test_glitch();
    int len;
    for (int rep = 0; rep < 3; rep++) begin
      clear_mon();
      len = $urandom_range(1, 3);
      rx_a = 1'b0; tick(len);
      rx_a = 1'b1; tick(3 * CPB_A);
      n_tests++; if (dvb_a.size() + fec_a.size() !== 0) begin n_fail++; $display("FAIL glitch_pulses got %0d want 0", dvb_a.size() + fec_a.size()); end
      n_tests++; if (act_cnt_a !== 4) begin n_fail++; $display("FAIL glitch_active_cycles len %0d got %0d want 4", len, act_cnt_a); end
      n_tests++; if (act_a !== 1'b0) begin n_fail++; $display("FAIL glitch_idle got %b want 0", act_a); end
    end
  endtask

  task automatic test_frame_err();
    int k;
    clear_mon();
    send(0, 8'h55, 1'b1, k);
    tick(CPB_A);
    clear_mon();
    send(0, 8'hA3, 1'b0, k);
    tick(40);
    n_tests++; if (act_a !== 1'b1) begin n_fail++; $display("FAIL fe_break_active got %b want 1", act_a); end
    n_tests++; if (fec_a.size() !== 1) begin n_fail++; $display("FAIL fe_count got %0d want 1", fec_a.size()); end
    if (fec_a.size() >= 1) begin
      n_tests++; if (fec_a[0] !== exp_cyc(k, CPB_A)) begin n_fail++; $display("FAIL fe_time got %0d want %0d", fec_a[0], exp_cyc(k, CPB_A)); end
    end
    n_tests++; if (dvb_a.size() !== 0) begin n_fail++; $display("FAIL fe_no_dv got %0d want 0", dvb_a.size()); end
    n_tests++; if (rxb_a !== 8'h55) begin n_fail++; $display("FAIL fe_byte_kept got %h want 55", rxb_a); end
    rx_a = 1'b1;
    tick(2 * CPB_A);
    n_tests++; if (act_a !== 1'b0) begin n_fail++; $display("FAIL fe_release got %b want 0", act_a); end
    n_tests++; if (dvb_a.size() + fec_a.size() !== 1) begin n_fail++; $display("FAIL fe_no_retrigger got %0d want 1", dvb_a.size() + fec_a.size()); end
  endtask

  task automatic test_back_to_back();
    int k0, k1, d;
    clear_mon();
    send(0, 8'h00, 1'b1, k0);
    send(0, 8'hFF, 1'b1, k1);
    tick(2 * CPB_A);
    n_tests++; if (dvb_a.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", dvb_a.size()); end
    if (dvb_a.size() >= 2) begin
      n_tests++; if ({dvb_a[0], dvb_a[1]} !== 16'h00FF) begin n_fail++; $display("FAIL b2b_bytes got %h want 00ff", {dvb_a[0], dvb_a[1]}); end
      d = dvc_a[1] - dvc_a[0] - 10 * CPB_A;
      n_tests++; if (d < -1 || d > 1) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", dvc_a[1] - dvc_a[0], 10 * CPB_A); end
    end
    n_tests++; if (fec_a.size() !== 0) begin n_fail++; $display("FAIL b2b_no_fe got %0d want 0", fec_a.size()); end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [7:0] b;
    clear_mon();
    b = 8'($urandom);
    rx_a = 1'b0; tick(CPB_A);
    for (int i = 0; i < 4; i++) begin rx_a = b[i]; tick(CPB_A); end
    rx_a = b[4]; tick(CPB_A / 2);
    rst = 1'b1; rx_a = 1'b1;
    tick(1);
    n_tests++; if ({dv_a, act_a, fe_a, rxb_a} !== 11'd0) begin n_fail++; $display("FAIL midreset_outputs got %h want 0", {dv_a, act_a, fe_a, rxb_a}); end
    tick(2);
    rst = 1'b0;
    tick(3 * CPB_A);
    n_tests++; if (dvb_a.size() + fec_a.size() !== 0) begin n_fail++; $display("FAIL midreset_no_pulse got %0d want 0", dvb_a.size() + fec_a.size()); end
    send(0, 8'h3C, 1'b1, k);
    tick(CPB_A);
    n_tests++; if (dvb_a.size() !== 1) begin n_fail++; $display("FAIL midreset_next_count got %0d want 1", dvb_a.size()); end
    n_tests++; if (rxb_a !== 8'h3C) begin n_fail++; $display("FAIL midreset_next_byte got %h want 3c", rxb_a); end
  endtask

  task automatic test_stream_a();
    int k, gap;
    logic [7:0] exp_b[$];
    int exp_c[$];
    clear_mon();
    for (int v = 0; v < 256; v++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) tick(gap);
      send(0, 8'(v), 1'b1, k);
      exp_b.push_back(8'(v));
      exp_c.push_back(exp_cyc(k, CPB_A));
    end
    tick(2 * CPB_A);
    n_tests++; if (dvb_a.size() !== 256) begin n_fail++; $display("FAIL stream_a_count got %0d want 256", dvb_a.size()); end
    for (int i = 0; i < 256 && i < dvb_a.size(); i++) begin
      n_tests++; if (dvb_a[i] !== exp_b[i]) begin n_fail++; $display("FAIL stream_a_byte[%0d] got %h want %h", i, dvb_a[i], exp_b[i]); end
      n_tests++; if (dvc_a[i] !== exp_c[i]) begin n_fail++; $display("FAIL stream_a_time[%0d] got %0d want %0d", i, dvc_a[i], exp_c[i]); end
    end
    n_tests++; if (fec_a.size() !== 0) begin n_fail++; $display("FAIL stream_a_fe got %0d want 0", fec_a.size()); end
  endtask

  task automatic test_stream_b();
    int k, gap;
    logic [7:0] b;
    logic [7:0] exp_b[$];
    clear_mon();
    for (int n = 0; n < 24; n++) begin
      gap = $urandom_range(0, 5);
      if (gap > 0) tick(gap);
      b = 8'($urandom);
      send(1, b, 1'b1, k);
      exp_b.push_back(b);
    end
    tick(2 * CPB_B);
    n_tests++; if (dvb_b.size() !== 24) begin n_fail++; $display("FAIL stream_b_count got %0d want 24", dvb_b.size()); end
    for (int i = 0; i < 24 && i < dvb_b.size(); i++) begin
      n_tests++; if (dvb_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL stream_b_byte[%0d] got %h want %h", i, dvb_b[i], exp_b[i]); end
    end
    n_tests++; if (fec_b.size() !== 0) begin n_fail++; $display("FAIL stream_b_fe got %0d want 0", fec_b.size()); end
  endtask

  task automatic test_pulse_rules();
    n_tests++; if (viol_a !== 0) begin n_fail++; $display("FAIL pulse_rules_a got %0d want 0", viol_a); end
    n_tests++; if (viol_b !== 0) begin n_fail++; $display("FAIL pulse_rules_b got %0d want 0", viol_b); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_stream_a();
    test_stream_b();
    test_pulse_rules();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
